mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single unified memory with a ready handshake.
// Define MEM_ARB_FAIR_EN to bound the number of data grants in a row while a fetch is waiting.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR       = 10,
  parameter int FAIR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [ADDR-1:0]  i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ack,
  input  logic             d_req,
  input  logic [3:0]       d_we,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state_q, state_d;
  logic             mem_en_q, mem_en_d;
  logic [3:0]       mem_we_q, mem_we_d;
  logic [ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             grant_i, grant_d, fair_turn, idle_free;

  // The ack cycle is a turnaround: no grant at all, so a requester still holding its
  // request for the just-finished access cannot be granted twice, and a continuously
  // held data request keeps outranking a waiting fetch.
  assign idle_free = ~i_ack_q & ~d_ack_q;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  logic [SW-1:0] streak_q, streak_d;

  assign fair_turn = i_req && (streak_q == SW'(FAIR_LIMIT));

  always_comb begin
    streak_d = streak_q;
    if (grant_i)
      streak_d = '0;
    else if (grant_d && i_req && (streak_q != SW'(FAIR_LIMIT)))
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  // Strict data priority: constant 0, FAIR_LIMIT has no effect in this build.
  assign fair_turn = (FAIR_LIMIT < 0) && i_req;
`endif

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE && idle_free) begin
      if (fair_turn)  grant_i = 1'b1;
      else if (d_req) grant_d = 1'b1;
      else if (i_req) grant_i = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_en_d    = 1'b1;
          mem_we_d    = 4'b0000;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_en_d  = 1'b0;
          i_rdata_d = mem_rdata;
          i_ack_d   = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          d_ack_d  = 1'b1;
          if (mem_we_q == 4'b0000) d_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as requests are driven and
// matched against memory-side grants and acks. Fairness expectations follow MEM_ARB_FAIR_EN.
module tb_mem_arbiter;
  localparam int W = 32;
  localparam int A = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [A-1:0]  i_addr = '0;
  logic [W-1:0]  i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic [3:0]    d_we = 4'b0000;
  logic [A-1:0]  d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic [W-1:0]  d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [A-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ready;
  logic          stall;

  mem_arbiter #(.WIDTH(W), .ADDR(A), .FAIR_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  // Memory model: contents are a fixed function of address; ready after ready_delay busy cycles.
  function automatic logic [W-1:0] mem_word(input logic [A-1:0] a);
    return ({22'd0, a} * 32'h0100_0193) ^ 32'h5A5A_C3C3;
  endfunction

  int   ready_delay = 0;
  logic tie_ready = 1'b0;
  int   busy_cnt = 0;
  assign mem_rdata = mem_word(mem_addr);
  assign mem_ready = tie_ready | (mem_en && (busy_cnt >= ready_delay));
  always @(posedge clk) busy_cnt <= (mem_en && !mem_ready) ? busy_cnt + 1 : 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_data;
    logic [A-1:0] addr;
    logic [3:0]  we;
    logic [W-1:0] wdata;
    int          lat;
  } xact_t;

  xact_t        grant_q[$];
  xact_t        cur;
  bit           inflight = 1'b0;
  int           en_cycles = 0;
  logic [W-1:0] exp_i = '0;
  logic [W-1:0] exp_d = '0;
  logic         rst_at_edge = 1'b1;

  task automatic expect_grant(input bit is_data, input logic [A-1:0] a,
                              input logic [3:0] we, input logic [W-1:0] wd);
    xact_t x;
    x.is_data = is_data;
    x.addr    = a;
    x.we      = is_data ? we : 4'b0000;
    x.wdata   = wd;
    x.lat     = tie_ready ? 1 : ready_delay + 1;
    grant_q.push_back(x);
  endtask

  always @(posedge clk) rst_at_edge <= reset;

  // Monitor: matches grants, hold stability, acks, latency and read-data holding.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      inflight  = 1'b0;
      en_cycles = 0;
      exp_i     = '0;
      exp_d     = '0;
      check_eq("rst_ctrl", 32'({mem_en, mem_we, i_ack, d_ack}), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
    end else begin
      if (mem_en) begin
        if (!inflight) begin
          check_eq("grant_expected", 32'(grant_q.size() > 0), 32'd1);
          if (grant_q.size() > 0) begin
            cur = grant_q.pop_front();
            check_eq("grant_addr", 32'(mem_addr), 32'(cur.addr));
            check_eq("grant_we", 32'(mem_we), 32'(cur.we));
            if (cur.is_data) check_eq("grant_wdata", mem_wdata, cur.wdata);
          end
          inflight  = 1'b1;
          en_cycles = 1;
        end else begin
          en_cycles++;
          check_eq("hold_addr_we", 32'({mem_addr, mem_we}), 32'({cur.addr, cur.we}));
          if (cur.is_data) check_eq("hold_wdata", mem_wdata, cur.wdata);
        end
      end
      if (i_ack || d_ack) begin
        check_eq("ack_port", 32'({i_ack, d_ack}),
                 inflight ? (cur.is_data ? 32'd1 : 32'd2) : 32'd0);
        if (inflight) begin
          check_eq("ack_latency", en_cycles, cur.lat);
          if (!cur.is_data) exp_i = mem_word(cur.addr);
          else if (cur.we == 4'b0000) exp_d = mem_word(cur.addr);
          $display("[TB] %0t %s addr=0x%03h we=%b lat=%0d i_rdata=0x%08h d_rdata=0x%08h",
                   $time, cur.is_data ? "DATA " : "FETCH", cur.addr, cur.we, en_cycles,
                   i_rdata, d_rdata);
        end
        inflight = 1'b0;
      end
      check_eq("i_rdata", i_rdata, exp_i);
      check_eq("d_rdata", d_rdata, exp_d);
    end
  end

  task automatic wait_i_acks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (i_ack) seen++;
    end
    check_eq("i_ack_count", seen, n);
  endtask

  task automatic wait_d_acks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (d_ack) seen++;
    end
    check_eq("d_ack_count", seen, n);
  endtask

  task automatic fetch_port(input logic [A-1:0] a);
    @(posedge clk); #1;
    i_req  = 1'b1;
    i_addr = a;
    wait_i_acks(1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic data_port(input logic [3:0] we, input logic [A-1:0] a,
                           input logic [W-1:0] wd, input int n);
    @(posedge clk); #1;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    wait_d_acks(n);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [A-1:0] a;

    // Reset: outputs cleared, no stall with requests low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Minimum-latency fetch, mem_ready tied high (also high in IDLE, must be ignored)
    tie_ready = 1'b1;
    expect_grant(1'b0, 10'h010, 4'b0000, '0);
    @(posedge clk); #1;
    i_req  = 1'b1;
    i_addr = 10'h010;
    @(negedge clk);
    check_eq("c0_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    check_eq("c1_mem_en", 32'(mem_en), 32'd1);
    check_eq("c1_mem_addr", 32'(mem_addr), 32'h010);
    check_eq("c1_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check_eq("c2_i_ack", 32'(i_ack), 32'd1);
    check_eq("c2_i_rdata", i_rdata, mem_word(10'h010));
    check_eq("c2_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check_eq("c3_i_ack_pulse", 32'(i_ack), 32'd0);
    tie_ready = 1'b0;

    // Mixed loads and fetches with varying memory latency
    for (int k = 0; k < 6; k++) begin
      ready_delay = k % 3;
      a = A'($urandom_range(0, 1023));
      if (k % 2 == 0) begin
        expect_grant(1'b1, a, 4'b0000, '0);
        data_port(4'b0000, a, 32'h0, 1);
      end else begin
        expect_grant(1'b0, a, 4'b0000, '0);
        fetch_port(a);
      end
    end

    // Store with delayed ready: held 4 cycles, single ack, d_rdata unchanged
    ready_delay = 3;
    expect_grant(1'b1, 10'h2A4, 4'b0011, 32'hDEADBEEF);
    data_port(4'b0011, 10'h2A4, 32'hDEADBEEF, 1);
    @(negedge clk);
    check_eq("store_ack_pulse", 32'(d_ack), 32'd0);

    // Simultaneous requests: data first, fetch after the ack turnaround
    ready_delay = 0;
    expect_grant(1'b1, 10'h100, 4'b0000, '0);
    expect_grant(1'b0, 10'h204, 4'b0000, '0);
    fork
      data_port(4'b0000, 10'h100, 32'h0, 1);
      fetch_port(10'h204);
    join

    // Fetch waiting under a continuous data stream
    ready_delay = 0;
`ifdef MEM_ARB_FAIR_EN
    for (int k = 0; k < 3; k++) expect_grant(1'b1, 10'h0C8, 4'b0000, '0);
    expect_grant(1'b0, 10'h3F0, 4'b0000, '0);
    for (int k = 0; k < 2; k++) expect_grant(1'b1, 10'h0C8, 4'b0000, '0);
`else
    for (int k = 0; k < 5; k++) expect_grant(1'b1, 10'h0C8, 4'b0000, '0);
    expect_grant(1'b0, 10'h3F0, 4'b0000, '0);
`endif
    fork
      data_port(4'b0000, 10'h0C8, 32'h0, 5);
      fetch_port(10'h3F0);
    join

    // Reset while BUSY_D: access abandoned, no ack, stall from held request
    ready_delay = 1000;
    expect_grant(1'b1, 10'h155, 4'b0000, '0);
    @(posedge clk); #1;
    d_req  = 1'b1;
    d_we   = 4'b0000;
    d_addr = 10'h155;
    @(negedge clk);
    @(negedge clk);
    check_eq("r_busy_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("r_mem_en", 32'(mem_en), 32'd0);
    check_eq("r_d_ack", 32'(d_ack), 32'd0);
    check_eq("r_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("r_idle_en", 32'(mem_en), 32'd0);
    check_eq("r_idle_ack", 32'(d_ack), 32'd0);

    check_eq("grants_left", grant_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
